// File: rtl/scan_mux_pkg.sv
// Shared types and helpers for the scan_mux block: mode/state encodings and
// a constant-foldable clog2 for deriving select widths.
package scan_mux_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic {
      ST_MANUAL = 1'b0,
      ST_SCAN   = 1'b1
   } state_t;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/scan_mux_if.sv
// Channel/select bus of scan_mux. The ch_en mask signal exists only when
// SCAN_MUX_MASK_EN is defined.
interface scan_mux_if import scan_mux_pkg::*; #(
   parameter int CH = 4,
   parameter int W  = 8
) ();
   localparam int SEL_W = clog2(CH);

   logic              mode;
   logic [SEL_W-1:0]  sel;
   logic [CH*W-1:0]   din;
`ifdef SCAN_MUX_MASK_EN
   logic [CH-1:0]     ch_en;
`endif
   logic [W-1:0]      dout;
   logic [SEL_W-1:0]  cur_ch;
   logic              out_valid;
   logic              wrap;

   modport master (
      output mode, sel, din,
`ifdef SCAN_MUX_MASK_EN
      output ch_en,
`endif
      input  dout, cur_ch, out_valid, wrap
   );

   modport slave (
      input  mode, sel, din,
`ifdef SCAN_MUX_MASK_EN
      input  ch_en,
`endif
      output dout, cur_ch, out_valid, wrap
   );

endinterface

// File: rtl/scan_next_ch.sv
// Combinational round-robin finder: first set mask bit strictly after cur,
// searching upward modulo CH (cur itself is found last).
module scan_next_ch import scan_mux_pkg::*; #(
   parameter int CH    = 4,
   parameter int SEL_W = clog2(CH)
) (
   input  logic [SEL_W-1:0] cur,
   input  logic [CH-1:0]    mask,
   output logic [SEL_W-1:0] nxt,
   output logic             wrapped,
   output logic             none_enabled
);

   function automatic logic [SEL_W-1:0] ch_add(input logic [SEL_W-1:0] c,
                                               input int unsigned k);
      int unsigned s;
      s = 32'(c) + k;
      if (s >= 32'(CH)) s = s - 32'(CH);
      return SEL_W'(s);
   endfunction

   // Walk offsets from farthest to nearest so the nearest enabled hit wins.
   always_comb begin
      nxt          = cur;
      none_enabled = 1'b1;
      for (int unsigned i = 0; i < 32'(CH); i++) begin
         if (mask[ch_add(cur, 32'(CH) - i)]) begin
            nxt          = ch_add(cur, 32'(CH) - i);
            none_enabled = 1'b0;
         end
      end
      wrapped = !none_enabled && (nxt <= cur);
   end

endmodule

// File: rtl/scan_mux.sv
// N-channel registered mux with MANUAL select and SCAN dwell/advance modes.
// Define SCAN_MUX_MASK_EN to add the per-channel ch_en scan mask.
module scan_mux import scan_mux_pkg::*; #(
   parameter int CH    = 4,
   parameter int W     = 8,
   parameter int DWELL = 4
) (
   input logic       clk,
   input logic       rst,
   scan_mux_if.slave bus
);
   localparam int SEL_W = clog2(CH);
   localparam int CNT_W = (DWELL > 1) ? clog2(DWELL) : 1;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [SEL_W-1:0]   r_cur;
   logic [SEL_W-1:0]   w_nxt;
   logic [W-1:0]       r_dout;
   logic [W-1:0]       w_dout_nxt;
   logic               r_valid;
   logic               w_valid_nxt;
   logic               r_wrap;
   logic               w_wrap_nxt;
   logic [CH-1:0]      w_mask;
   logic [SEL_W-1:0]   w_adv;
   logic               w_adv_wrap;
   logic               w_none;

`ifdef SCAN_MUX_MASK_EN
   assign w_mask = bus.ch_en;
`else
   assign w_mask = '1;
`endif

   scan_next_ch #(.CH(CH), .SEL_W(SEL_W)) u_next (
      .cur          (r_cur),
      .mask         (w_mask),
      .nxt          (w_adv),
      .wrapped      (w_adv_wrap),
      .none_enabled (w_none)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_MANUAL;
         r_cnt   <= '0;
         r_cur   <= '0;
         r_dout  <= '0;
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cur   <= w_nxt;
         r_dout  <= w_dout_nxt;
         r_valid <= w_valid_nxt;
         r_wrap  <= w_wrap_nxt;
      end
   end

   always_comb begin
      w_state_nxt = (bus.mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
   end

   // Channel choice follows the incoming mode on the same edge; a state change
   // leaves the counter at 0 and holds the index, giving a full first dwell.
   always_comb begin
      w_nxt       = r_cur;
      w_cnt_nxt   = '0;
      w_wrap_nxt  = 1'b0;
      w_valid_nxt = 1'b1;
      w_dout_nxt  = '0;
      if (w_state_nxt == ST_MANUAL) begin
         if (32'(bus.sel) < CH) w_nxt = bus.sel;
      end else if (w_none) begin
         w_valid_nxt = 1'b0;
      end else if (r_state == ST_SCAN) begin
         if (r_cnt == CNT_W'(DWELL - 1)) begin
            w_nxt      = w_adv;
            w_wrap_nxt = w_adv_wrap;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
      end
      if (w_valid_nxt) w_dout_nxt = bus.din[int'(w_nxt) * W +: W];
   end

   assign bus.dout      = r_dout;
   assign bus.cur_ch    = r_cur;
   assign bus.out_valid = r_valid;
   assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: a CH=4/DWELL=3 and a CH=5/DWELL=2 instance,
// directed scenarios followed by random stimulus against a dwell-age model.
module tb_scan_mux;
   import scan_mux_pkg::*;

   typedef struct {
      bit scan;
      int age;
      int cur;
   } mstate_t;

   typedef struct {
      logic [7:0] dout;
      int         cur;
      bit         valid;
      bit         wrap;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   scan_mux_if #(.CH(4), .W(8)) b4 ();
   scan_mux_if #(.CH(5), .W(8)) b5 ();

   scan_mux #(.CH(4), .W(8), .DWELL(3)) dut4 (.clk(clk), .rst(rst), .bus(b4));
   scan_mux #(.CH(5), .W(8), .DWELL(2)) dut5 (.clk(clk), .rst(rst), .bus(b5));

   exp_t    q4[$];
   exp_t    q5[$];
   mstate_t m4;
   mstate_t m5;
   int      total = 0;
   int      bad   = 0;
   logic [3:0] en4 = 4'hF;
   logic [4:0] en5 = 5'h1F;

   // Channel k is shown for `dwell` cycles counted from the edge it first appears.
   function automatic exp_t step(inout mstate_t s, input bit r, input bit m,
                                 input int sel, input int ch, input int dwell,
                                 input logic [7:0] d[5], input bit [4:0] en);
      exp_t e;
      int   c;
      e.valid = 1'b1;
      e.wrap  = 1'b0;
      if (r) begin
         s.scan = 1'b0; s.age = 1; s.cur = 0;
         e.valid = 1'b0; e.cur = 0; e.dout = 8'h00;
         return e;
      end
      if (!m) begin
         s.scan = 1'b0;
         if (sel < ch) s.cur = sel;
      end else if (en == 5'b0) begin
         s.scan = 1'b1; s.age = 1; e.valid = 1'b0;
      end else if (!s.scan) begin
         s.scan = 1'b1; s.age = 1;
      end else if (s.age < dwell) begin
         s.age = s.age + 1;
      end else begin
         c = (s.cur + 1) % ch;
         while (!en[c]) c = (c + 1) % ch;
         e.wrap = (c <= s.cur);
         s.cur  = c;
         s.age  = 1;
      end
      e.cur  = s.cur;
      e.dout = e.valid ? d[s.cur] : 8'h00;
      return e;
   endfunction

   task automatic set_en(input logic [3:0] a, input logic [4:0] b);
      en4 = a;
      en5 = b;
`ifdef SCAN_MUX_MASK_EN
      b4.ch_en = a;
      b5.ch_en = b;
`endif
   endtask

   function automatic bit [4:0] mask4();
`ifdef SCAN_MUX_MASK_EN
      return {1'b0, en4};
`else
      return 5'b01111;
`endif
   endfunction

   function automatic bit [4:0] mask5();
`ifdef SCAN_MUX_MASK_EN
      return en5;
`else
      return 5'b11111;
`endif
   endfunction

   task automatic tick();
      logic [7:0] d[5];
      for (int k = 0; k < 5; k++) d[k] = (k < 4) ? b4.din[k*8 +: 8] : 8'h00;
      q4.push_back(step(m4, rst, b4.mode, int'(b4.sel), 4, 3, d, mask4()));
      for (int k = 0; k < 5; k++) d[k] = b5.din[k*8 +: 8];
      q5.push_back(step(m5, rst, b5.mode, int'(b5.sel), 5, 2, d, mask5()));
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (q4.size() > 0) begin
            e = q4.pop_front();
            chk("c4.valid", 32'(b4.out_valid), 32'(e.valid));
            chk("c4.cur",   32'(b4.cur_ch),    32'(e.cur));
            chk("c4.dout",  32'(b4.dout),      32'(e.dout));
            chk("c4.wrap",  32'(b4.wrap),      32'(e.wrap));
         end
         if (q5.size() > 0) begin
            e = q5.pop_front();
            chk("c5.valid", 32'(b5.out_valid), 32'(e.valid));
            chk("c5.cur",   32'(b5.cur_ch),    32'(e.cur));
            chk("c5.dout",  32'(b5.dout),      32'(e.dout));
            chk("c5.wrap",  32'(b5.wrap),      32'(e.wrap));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog t=%0t got=running exp=finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      m4 = '{scan: 1'b0, age: 1, cur: 0};
      m5 = '{scan: 1'b0, age: 1, cur: 0};
      rst = 1'b1;
      b4.mode = MODE_MANUAL; b4.sel = '0; b4.din = 32'h44332211;
      b5.mode = MODE_MANUAL; b5.sel = '0; b5.din = 40'h5544332211;
      set_en(4'b1111, 5'b11111);
      tick(); tick();
      rst = 1'b0;
      tick();
      b4.sel = 2'd2; b5.sel = 3'd1;
      tick();
      b5.sel = 3'd6;
      tick();
      b5.din[15:8] = 8'hA7;
      tick(); tick();
      b4.sel = 2'd0;
      tick();
      b4.mode = MODE_SCAN;
      repeat (13) tick();
      set_en(4'b0101, 5'b00101);
      repeat (8) tick();
      set_en(4'b0000, 5'b00000);
      tick(); tick();
      set_en(4'b1000, 5'b10000);
      repeat (6) tick();
      set_en(4'b1111, 5'b11111);
      repeat (4) tick();
      b4.mode = MODE_MANUAL; b4.sel = 2'd3;
      tick();
      b4.mode = MODE_SCAN;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      for (int n = 0; n < 320; n++) begin
         rst = ($urandom_range(99) == 0);
         if ($urandom_range(19) == 0) b4.mode = ~b4.mode;
         if ($urandom_range(19) == 0) b5.mode = ~b5.mode;
         b4.sel = 2'($urandom);
         b5.sel = 3'($urandom);
         b4.din = $urandom;
         b5.din = {8'($urandom), $urandom};
         if ($urandom_range(9) == 0)
            set_en(($urandom_range(3) == 0) ? 4'b0 : 4'($urandom),
                   ($urandom_range(3) == 0) ? 5'b0 : 5'($urandom));
         tick();
      end
      rst = 1'b0;
      #5;
      chk("q4.drain", 32'(q4.size()), 32'd0);
      chk("q5.drain", 32'(q5.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised N-channel, W-bit registered multiplexer. It is the successor to the team's fixed 4:1 single-bit combinational mux. It selects one of CH data channels either from an explicit select (MANUAL) or by automatically scanning channels with a programmable dwell time (SCAN). It feeds time-multiplexed consumers such as display digit drivers and shared result buses in the lab datapaths.

## Interface
- CH, 4, number of input channels (≥2)
- W, 8, data width per channel (≥1)
- DWELL, 4, cycles spent on each channel in SCAN mode (≥1)
- SEL_W, derived = clog2(CH), select/index width (localparam)

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- mode  in  1  0 = MANUAL, 1 = SCAN
- sel  in  SEL_W  channel select, used in MANUAL only
- din  in  CH*W  flattened channels; channel k = din[k*W +: W]
- ch_en  in  CH  per-channel scan enable (present only with SCAN_MUX_MASK_EN)
- dout  out  W  registered selected data
- cur_ch  out  SEL_W  channel index that dout came from
- out_valid  out  1  dout is valid
- wrap  out  1  one-cycle pulse when the scan returns to a lower-or-equal index

## Operation
- State machine: MANUAL, SCAN.
  - Reset enters MANUAL.
  - Each non-reset edge, the state follows mode.
  - Any state change clears the dwell counter.
- Every edge computes next channel nxt, then registers cur_ch <= nxt and dout <= din[nxt]. dout and cur_ch are always consistent.
- MANUAL:
  - nxt = sel if sel < CH; otherwise nxt = cur_ch (hold index, data still refreshed).
  - Mask ignored. wrap = 0.
- SCAN:
  - Dwell counter counts 0..DWELL-1.
  - At DWELL-1, nxt = next enabled channel after cur_ch, searching upward modulo CH, and the counter returns to 0. Otherwise nxt = cur_ch.
  - wrap = 1 on the edge where the advance target ≤ cur_ch. This includes a single enabled channel advancing to itself.
  - MANUAL→SCAN: scanning starts from the current cur_ch with a full dwell.
- Without a mask, all CH channels are enabled.
- Mask, all channels disabled in SCAN:
  - out_valid <= 0, dout <= 0, cur_ch held, counter held at 0.
  - Recovers on the first edge after any bit of ch_en goes high.
- ch_en changing mid-dwell affects only the next advance. The current channel is never dropped early.
- DWELL = 1: advance every cycle.

## Timing
- Reset values: dout = 0, cur_ch = 0, out_valid = 0, wrap = 0, dwell = 0, state MANUAL.
- out_valid rises on the first edge with rst low. It stays 1 except in the all-masked SCAN case.
- Latency: 1 cycle from sel/din/mode sampling to dout.
- rst asserted mid-scan: reset values on that edge, overriding everything.

## Configuration
- SCAN_MUX_MASK_EN defined:
  - ch_en port exists.
  - SCAN skips disabled channels, and the all-disabled rule applies.
- Not defined:
  - ch_en is absent and all channels are scanned in order 0..CH-1.
  - out_valid never drops after reset.

## Structure
- Shared package scan_mux_pkg holds:
  - mode encodings MODE_MANUAL = 0, MODE_SCAN = 1
  - state encodings
  - a clog2 function
- Sub-module scan_next_ch: combinational next-enabled-channel finder.
  - Inputs: cur, mask.
  - Outputs: nxt, wrapped, none_enabled.
  - Reused for any round-robin selection elsewhere.

## Test plan
All cases use CH=4, W=8, DWELL=3, din ch0..3 = 11, 22, 33, 44 (hex).
- Reset: rst high 2 cycles → dout 00, cur_ch 0, out_valid 0, wrap 0. First edge with rst low, mode 0, sel 0 → dout 11, out_valid 1.
- MANUAL: sel 2 → next cycle dout 33, cur_ch 2. With CH=5 and sel=6: cur_ch holds, then changing that channel's din is visible on dout one cycle later.
- SCAN from ch0: cur_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. wrap high only with the return to 0.
- Mask (SCAN_MUX_MASK_EN), ch_en=0101:
  - sequence 0,0,0,2,2,2,0, with wrap on each return to 0.
  - ch_en=0000 → next edge out_valid 0, dout 00.
  - ch_en=1000 → valid returns and scan continues.
- Mode switch mid-dwell (SCAN, count 1) to MANUAL with sel 3 → next cycle dout 44.
- Back to SCAN → holds ch3 for 3 cycles, then 0 with wrap.
- rst asserted mid-scan → reset values next edge.
